state_sequencer: RTL and testbench

- Next-state engine for the multicycle core. Decodes the latched instruction register, the ALU/flag status and the memory handshake, and produces the StateID consumed by the datapath control decoder.
- Owns all sequencing: fetch/decode, conditional-execute skip, memory wait, branch resolution and the LM/SM register-mask loop.
- Sits between IR/flags/memory and the control decoder. It drives no datapath mux itself.

---
 rtl/state_sequencer.sv | 169 ++++++++++++++++
 tb/tb_state_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/state_sequencer.sv
// Next-state engine for the multicycle core: turns IR, flags and memory handshake into the
// registered StateID that drives the control decoder, including the LM/SM register-mask loop.
module state_sequencer #(
    parameter int unsigned SW     = 5,
    parameter int unsigned MASK_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   ir,
    input  logic          mem_ready,
    input  logic          carry_flag,
    input  logic          zero_flag,
    input  logic          alu_zero,
    output logic [SW-1:0] state_id,
    output logic [2:0]    lsm_reg,
    output logic          lsm_active,
    output logic          instr_done,
    output logic          illegal_op
);

    typedef enum logic [SW-1:0] {
        StFetch   = SW'(0),
        StDecode  = SW'(1),
        StRExec   = SW'(2),
        StRWb     = SW'(3),
        StIExec   = SW'(4),
        StIWb     = SW'(5),
        StLhiWb   = SW'(6),
        StAddr    = SW'(7),
        StMemRd   = SW'(8),
        StLdWb    = SW'(9),
        StMemWr   = SW'(10),
        StBeqCmp  = SW'(11),
        StBrTake  = SW'(12),
        StJalLink = SW'(13),
        StJalTgt  = SW'(14),
        StJlrTgt  = SW'(15),
        StLsmInit = SW'(16),
        StLsmXfer = SW'(17),
        StPcInc   = SW'(18),
        StHaltErr = SW'(19)
    } state_e;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpAdi = 4'b0001;
    localparam logic [3:0] OpNdu = 4'b0010;
    localparam logic [3:0] OpLhi = 4'b0011;
    localparam logic [3:0] OpLw  = 4'b0100;
    localparam logic [3:0] OpSw  = 4'b0101;
    localparam logic [3:0] OpLm  = 4'b0110;
    localparam logic [3:0] OpSm  = 4'b0111;
    localparam logic [3:0] OpJal = 4'b1000;
    localparam logic [3:0] OpJlr = 4'b1001;
    localparam logic [3:0] OpBeq = 4'b1100;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [2:0]        reg_q, reg_d;
    logic              ill_q, ill_d;
    logic [MASK_W-1:0] rem_mask;
    logic              unused_ir;

    // ir[11:8] carries register operands used only by the datapath.
    assign unused_ir = ^ir[11:8];

    function automatic logic [2:0] lowest_set(input logic [MASK_W-1:0] m);
        lowest_set = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = 3'(i);
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            op_q    <= '0;
            mask_q  <= '0;
            reg_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            reg_q   <= reg_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mask_d   = mask_q;
        reg_d    = reg_q;
        ill_d    = ill_q;
        rem_mask = mask_q & ~(MASK_W'(1) << reg_q);

        unique case (state_q)
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                op_d = ir[15:12];
                case (ir[15:12])
                    OpAdd, OpNdu: begin
                        case (ir[1:0])
                            2'b00: state_d = StRExec;
                            2'b10: state_d = carry_flag ? StRExec : StPcInc;
                            2'b01: state_d = zero_flag ? StRExec : StPcInc;
                            default: begin
                                state_d = StHaltErr;
                                ill_d   = 1'b1;
                            end
                        endcase
                    end
                    OpAdi:        state_d = StIExec;
                    OpLhi:        state_d = StLhiWb;
                    OpLw, OpSw:   state_d = StAddr;
                    OpLm, OpSm:   state_d = StLsmInit;
                    OpBeq:        state_d = StBeqCmp;
                    OpJal, OpJlr: state_d = StJalLink;
                    default: begin
                        state_d = StHaltErr;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            StRExec:   state_d = StRWb;
            StRWb:     state_d = StPcInc;
            StIExec:   state_d = StIWb;
            StIWb:     state_d = StPcInc;
            StLhiWb:   state_d = StPcInc;
            StAddr:    state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready) state_d = StLdWb;
            StLdWb:    state_d = StPcInc;
            StMemWr:   if (mem_ready) state_d = StPcInc;
            StBeqCmp:  state_d = alu_zero ? StBrTake : StPcInc;
            StJalLink: state_d = (op_q == OpJlr) ? StJlrTgt : StJalTgt;
            StBrTake, StJalTgt, StJlrTgt, StPcInc: state_d = StFetch;
            StLsmInit: begin
                mask_d = ir[MASK_W-1:0];
                if (ir[MASK_W-1:0] == '0) begin
                    state_d = StPcInc;
                end else begin
                    reg_d   = lowest_set(ir[MASK_W-1:0]);
                    state_d = StLsmXfer;
                end
            end
            StLsmXfer: begin
                if (mem_ready) begin
                    mask_d = rem_mask;
                    if (rem_mask == '0) begin
                        state_d = StPcInc;
                    end else begin
                        reg_d = lowest_set(rem_mask);
                    end
                end
            end
            StHaltErr: ill_d = 1'b1;
            default:   state_d = StFetch;
        endcase
    end

    assign state_id   = state_q;
    assign lsm_reg    = reg_q;
    assign illegal_op = ill_q;
    assign lsm_active = (state_q == StLsmXfer);
    assign instr_done = (state_q == StBrTake) || (state_q == StJalTgt) ||
                        (state_q == StJlrTgt) || (state_q == StPcInc);

endmodule

// File: tb/tb_state_sequencer.sv
// Self-checking bench for state_sequencer: table of single-instruction state walks plus
// hand-written sequences for memory waits, the LM/SM loop, reset abort and illegal opcodes.
module tb_state_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic        mem_ready, carry_flag, zero_flag, alu_zero;
    logic [4:0]  state_id;
    logic [2:0]  lsm_reg;
    logic        lsm_active, instr_done, illegal_op;

    int errors = 0;
    int checks = 0;

    state_sequencer #(.SW(5), .MASK_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir         (ir),
        .mem_ready  (mem_ready),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .alu_zero   (alu_zero),
        .state_id   (state_id),
        .lsm_reg    (lsm_reg),
        .lsm_active (lsm_active),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] st;
        logic       done;
        logic       chk_reg;
        logic [2:0] rg;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [15:0] ir;
        logic        c;
        logic        z;
        logic        az;
        int          n;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   seqs[16][6];

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic push(input int st, input bit done, input bit chk_reg, input int rg,
                        input bit ill);
        exp_t e;
        e.st = 5'(st); e.done = done; e.chk_reg = chk_reg; e.rg = 3'(rg); e.ill = ill;
        sb.push_back(e);
    endtask

    // Called at a falling edge: compare against the oldest expectation, then advance a cycle.
    task automatic pop_check(input bit mr_next);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("state_id", int'(state_id), int'(e.st));
            check("instr_done", int'(instr_done), int'(e.done));
            check("lsm_active", int'(lsm_active), int'(e.st == 5'd17));
            check("illegal_op", int'(illegal_op), int'(e.ill));
            if (e.chk_reg) check("lsm_reg", int'(lsm_reg), int'(e.rg));
        end
        mem_ready = mr_next;
        @(negedge clk);
    endtask

    task automatic step(input int st, input bit done, input bit chk_reg, input int rg,
                        input bit ill, input bit mr_next);
        push(st, done, chk_reg, rg, ill);
        pop_check(mr_next);
    endtask

    task automatic check_reset_outputs();
        check("rst_state_id", int'(state_id), 0);
        check("rst_lsm_reg", int'(lsm_reg), 0);
        check("rst_lsm_active", int'(lsm_active), 0);
        check("rst_instr_done", int'(instr_done), 0);
        check("rst_illegal_op", int'(illegal_op), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{16'h0A40, 1'b0, 1'b0, 1'b0, 5}; seqs[0]  = '{0, 1, 2, 3, 18, 0};
        vecs[1]  = '{16'h0A42, 1'b0, 1'b0, 1'b0, 3}; seqs[1]  = '{0, 1, 18, 0, 0, 0};
        vecs[2]  = '{16'h0A42, 1'b1, 1'b0, 1'b0, 5}; seqs[2]  = '{0, 1, 2, 3, 18, 0};
        vecs[3]  = '{16'h0A41, 1'b0, 1'b1, 1'b0, 5}; seqs[3]  = '{0, 1, 2, 3, 18, 0};
        vecs[4]  = '{16'h0A41, 1'b1, 1'b0, 1'b0, 3}; seqs[4]  = '{0, 1, 18, 0, 0, 0};
        vecs[5]  = '{16'h2A40, 1'b0, 1'b0, 1'b0, 5}; seqs[5]  = '{0, 1, 2, 3, 18, 0};
        vecs[6]  = '{16'h1A40, 1'b0, 1'b0, 1'b0, 5}; seqs[6]  = '{0, 1, 4, 5, 18, 0};
        vecs[7]  = '{16'h3A40, 1'b0, 1'b0, 1'b0, 4}; seqs[7]  = '{0, 1, 6, 18, 0, 0};
        vecs[8]  = '{16'h4A40, 1'b0, 1'b0, 1'b0, 6}; seqs[8]  = '{0, 1, 7, 8, 9, 18};
        vecs[9]  = '{16'h5A40, 1'b0, 1'b0, 1'b0, 5}; seqs[9]  = '{0, 1, 7, 10, 18, 0};
        vecs[10] = '{16'hC000, 1'b0, 1'b0, 1'b1, 4}; seqs[10] = '{0, 1, 11, 12, 0, 0};
        vecs[11] = '{16'hC000, 1'b0, 1'b0, 1'b0, 4}; seqs[11] = '{0, 1, 11, 18, 0, 0};
        vecs[12] = '{16'h8000, 1'b0, 1'b0, 1'b0, 4}; seqs[12] = '{0, 1, 13, 14, 0, 0};
        vecs[13] = '{16'h9000, 1'b0, 1'b0, 1'b0, 4}; seqs[13] = '{0, 1, 13, 15, 0, 0};
        vecs[14] = '{16'h6000, 1'b0, 1'b0, 1'b0, 4}; seqs[14] = '{0, 1, 16, 18, 0, 0};
        vecs[15] = '{16'h7001, 1'b0, 1'b0, 1'b0, 5}; seqs[15] = '{0, 1, 16, 17, 18, 0};

        rst_n = 1'b0; ir = '0; mem_ready = 1'b1;
        carry_flag = 1'b0; zero_flag = 1'b0; alu_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Each row starts in FETCH; its last listed state is the final one.
        for (int v = 0; v < 16; v++) begin
            ir = vecs[v].ir; carry_flag = vecs[v].c; zero_flag = vecs[v].z;
            alu_zero = vecs[v].az;
            for (int k = 0; k < vecs[v].n; k++)
                push(seqs[v][k], (k == vecs[v].n - 1), 1'b0, 0, 1'b0);
            for (int k = 0; k < vecs[v].n; k++) pop_check(1'b1);
        end

        // FETCH holds on mem_ready=0, then LW with a 3-cycle memory stall.
        ir = 16'h4A40;
        mem_ready = 1'b0;
        step(0, 0, 0, 0, 0, 1'b0);
        step(0, 0, 0, 0, 0, 1'b1);
        step(1, 0, 0, 0, 0, 1'b1);
        step(7, 0, 0, 0, 0, 1'b0);
        step(8, 0, 0, 0, 0, 1'b0);
        step(8, 0, 0, 0, 0, 1'b0);
        step(8, 0, 0, 0, 0, 1'b0);
        step(8, 0, 0, 0, 0, 1'b1);
        step(9, 0, 0, 0, 0, 1'b1);
        step(18, 1, 0, 0, 0, 1'b1);

        // LM 1010_0101 with one stall; ir changes during the transfer loop must be ignored.
        ir = 16'h60A5;
        step(0, 0, 0, 0, 0, 1'b1);
        step(1, 0, 0, 0, 0, 1'b1);
        step(16, 0, 0, 0, 0, 1'b1);
        ir = 16'h0000;
        step(17, 0, 1, 0, 0, 1'b1);
        step(17, 0, 1, 2, 0, 1'b0);
        step(17, 0, 1, 2, 0, 1'b1);
        step(17, 0, 1, 5, 0, 1'b1);
        step(17, 0, 1, 7, 0, 1'b1);
        step(18, 1, 0, 0, 0, 1'b1);

        // Reset asserted in the middle of an LSM transfer loop.
        ir = 16'h60FF;
        step(0, 0, 0, 0, 0, 1'b1);
        step(1, 0, 0, 0, 0, 1'b1);
        step(16, 0, 0, 0, 0, 1'b1);
        step(17, 0, 1, 0, 0, 1'b1);
        step(17, 0, 1, 1, 0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        ir = 16'h0A40;
        step(0, 0, 0, 0, 0, 1'b1);
        step(1, 0, 0, 0, 0, 1'b1);
        step(2, 0, 0, 0, 0, 1'b1);
        step(3, 0, 0, 0, 0, 1'b1);
        step(18, 1, 0, 0, 0, 1'b1);

        // Undefined opcode: HALT_ERR is sticky regardless of later ir values.
        ir = 16'hF000;
        step(0, 0, 0, 0, 0, 1'b1);
        step(1, 0, 0, 0, 0, 1'b1);
        ir = 16'h0A40;
        step(19, 0, 0, 0, 1, 1'b1);
        step(19, 0, 0, 0, 1, 1'b1);
        step(19, 0, 0, 0, 1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Condition field 11 on ADD is illegal.
        ir = 16'h0A43;
        step(0, 0, 0, 0, 0, 1'b1);
        step(1, 0, 0, 0, 0, 1'b1);
        step(19, 0, 0, 0, 1, 1'b1);
        step(19, 0, 0, 0, 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
